// File: rtl/cmulti_unit_if.sv
// Operand/result bundle for the combined integer / binary32 multiplier.
interface cmulti_unit_if;
    logic [31:0] int_input1;
    logic [31:0] int_input2;
    logic [31:0] fp_input1;
    logic [31:0] fp_input2;
    logic [63:0] int_output;
    logic [31:0] fp_output;
    logic        int_mode;

    // Operand source side: drives operands, observes registered results.
    modport master (
        output int_input1, int_input2, fp_input1, fp_input2,
        input  int_output, fp_output, int_mode
    );

    // Multiplier side: consumes operands, drives registered results.
    modport slave (
        input  int_input1, int_input2, fp_input1, fp_input2,
        output int_output, fp_output, int_mode
    );
endinterface

// File: rtl/cmulti_unit.sv
// Combined 32x32 unsigned integer and IEEE-754 binary32 multiplier.
// Both products are computed every cycle and registered (1-cycle latency).
// Subnormal inputs are flushed to zero; no subnormal results are produced.
module cmulti_unit (
    input logic        clk,
    input logic        rst_n,
    cmulti_unit_if.slave bus
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic        sign_a, sign_b, sign_r;
    logic [7:0]  exp_a, exp_b;
    logic [22:0] frac_a, frac_b;
    logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic [47:0] sig_prod;
    logic [22:0] mant;
    logic        guard, sticky, round_up;
    logic [23:0] mant_rnd;
    logic signed [10:0] exp_r;
    logic [31:0] fp_next;

    // Field decode and operand classification.
    always_comb begin
        sign_a = bus.fp_input1[31];
        sign_b = bus.fp_input2[31];
        exp_a  = bus.fp_input1[30:23];
        exp_b  = bus.fp_input2[30:23];
        frac_a = bus.fp_input1[22:0];
        frac_b = bus.fp_input2[22:0];
        sign_r = sign_a ^ sign_b;
        nan_a  = (exp_a == 8'hFF) && (frac_a != '0);
        nan_b  = (exp_b == 8'hFF) && (frac_b != '0);
        inf_a  = (exp_a == 8'hFF) && (frac_a == '0);
        inf_b  = (exp_b == 8'hFF) && (frac_b == '0);
        zero_a = (exp_a == 8'h00);
        zero_b = (exp_b == 8'h00);
    end

    // Significand product, normalization, round-to-nearest-even and special-case selection.
    always_comb begin
        sig_prod = {24'd0, 1'b1, frac_a} * {24'd0, 1'b1, frac_b};
        exp_r    = 11'(signed'({3'd0, exp_a})) + 11'(signed'({3'd0, exp_b})) - 11'sd127;
        if (sig_prod[47]) begin
            mant   = sig_prod[46:24];
            guard  = sig_prod[23];
            sticky = |sig_prod[22:0];
            exp_r  = exp_r + 11'sd1;
        end else begin
            mant   = sig_prod[45:23];
            guard  = sig_prod[22];
            sticky = |sig_prod[21:0];
        end
        round_up = guard & (sticky | mant[0]);
        mant_rnd = {1'b0, mant} + {23'd0, round_up};
        // A carry out of rounding leaves the fraction all zero; only the exponent moves.
        if (mant_rnd[23]) begin
            exp_r = exp_r + 11'sd1;
        end

        fp_next = {sign_r, exp_r[7:0], mant_rnd[22:0]};
        if (nan_a || nan_b) begin
            fp_next = QNAN;
        end else if ((inf_a && zero_b) || (inf_b && zero_a)) begin
            fp_next = QNAN;
        end else if (inf_a || inf_b) begin
            fp_next = {sign_r, 8'hFF, 23'd0};
        end else if (zero_a || zero_b) begin
            fp_next = {sign_r, 31'd0};
        end else if (exp_r >= 11'sd255) begin
            fp_next = {sign_r, 8'hFF, 23'd0};
        end else if (exp_r <= 11'sd0) begin
            fp_next = {sign_r, 31'd0};
        end
    end

    // Result registers; asynchronous clear discards anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.int_output <= '0;
            bus.fp_output  <= '0;
            bus.int_mode   <= 1'b0;
        end else begin
            bus.int_output <= {32'd0, bus.int_input1} * {32'd0, bus.int_input2};
            bus.fp_output  <= fp_next;
            bus.int_mode   <= (bus.int_input1 != '0) || (bus.int_input2 != '0);
        end
    end

endmodule

// File: tb/tb_cmulti_unit.sv
// Directed-vector bench for cmulti_unit with hand-computed expected results.
module tb_cmulti_unit;

    logic clk;
    logic rst_n;
    int unsigned vectors;
    int unsigned miscompares;

    cmulti_unit_if bus ();

    cmulti_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it if the observed value differs.
    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic drive(input logic [31:0] i1, input logic [31:0] i2,
                         input logic [31:0] f1, input logic [31:0] f2);
        bus.int_input1 = i1;
        bus.int_input2 = i2;
        bus.fp_input1  = f1;
        bus.fp_input2  = f2;
    endtask

    // Apply one vector, clock it in, and compare all three outputs.
    task automatic apply(input string tag,
                         input logic [31:0] i1, input logic [31:0] i2,
                         input logic [31:0] f1, input logic [31:0] f2,
                         input logic [63:0] want_int, input logic [31:0] want_fp,
                         input logic want_mode);
        drive(i1, i2, f1, f2);
        @(posedge clk);
        #1;
        check_val({tag, ".int"},  bus.int_output, want_int);
        check_val({tag, ".fp"},   {32'd0, bus.fp_output}, {32'd0, want_fp});
        check_val({tag, ".mode"}, {63'd0, bus.int_mode}, {63'd0, want_mode});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b1;
        drive(32'h0000_FFFF, 32'h0000_FFFF, 32'h4020_0000, 32'h4020_0000);

        // Asynchronous reset with nonzero operands, before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        check_val("rst.int",  bus.int_output, 64'd0);
        check_val("rst.fp",   {32'd0, bus.fp_output}, 64'd0);
        check_val("rst.mode", {63'd0, bus.int_mode}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check_val("rst_hold.int", bus.int_output, 64'd0);
        @(posedge clk);
        #1;
        check_val("rel.int",  bus.int_output, 64'h0000_0000_FFFE_0001);
        check_val("rel.fp",   {32'd0, bus.fp_output}, 64'h40C8_0000);
        check_val("rel.mode", {63'd0, bus.int_mode}, 64'd1);

        apply("int16",   32'h0000_FFFF, 32'h0000_FFFF, 32'h0, 32'h0,
              64'h0000_0000_FFFE_0001, 32'h0000_0000, 1'b1);
        apply("fp2p5sq", 32'h0, 32'h0, 32'h4020_0000, 32'h4020_0000,
              64'h0, 32'h40C8_0000, 1'b0);
        apply("fp2x2p5", 32'h0, 32'h0, 32'h4000_0000, 32'h4020_0000,
              64'h0, 32'h40A0_0000, 1'b0);
        apply("both",    32'h0000_FFFF, 32'h0000_FFFF, 32'h4020_0000, 32'h4020_0000,
              64'h0000_0000_FFFE_0001, 32'h40C8_0000, 1'b1);
        apply("rndmax",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h42DD_62B2, 32'h4326_75B6,
              64'hFFFF_FFFE_0000_0001, 32'h468F_F3CB, 1'b1);
        apply("onenz",   32'h0, 32'h0000_0005, 32'h3F80_0000, 32'h3F80_0000,
              64'h0, 32'h3F80_0000, 1'b1);
        apply("infx0",   32'h0, 32'h0, 32'h7F80_0000, 32'h0000_0000,
              64'h0, 32'h7FC0_0000, 1'b0);
        apply("ovf",     32'h0, 32'h0, 32'h7F00_0000, 32'h7F00_0000,
              64'h0, 32'h7F80_0000, 1'b0);
        apply("unf",     32'h0, 32'h0, 32'h0080_0000, 32'h0080_0000,
              64'h0, 32'h0000_0000, 1'b0);
        apply("neg",     32'h0, 32'h0, 32'hC000_0000, 32'h4000_0000,
              64'h0, 32'hC080_0000, 1'b0);
        apply("nan",     32'h0, 32'h0, 32'h7F80_0001, 32'h3F80_0000,
              64'h0, 32'h7FC0_0000, 1'b0);
        apply("ninf",    32'h0, 32'h0, 32'hFF80_0000, 32'h4000_0000,
              64'h0, 32'hFF80_0000, 1'b0);
        apply("subnz",   32'h0, 32'h0, 32'h0000_0001, 32'hC000_0000,
              64'h0, 32'h8000_0000, 1'b0);

        // Reset mid-stream: nonzero results must clear without a clock edge.
        apply("pre_rst", 32'h0000_0003, 32'h0000_0007, 32'h4000_0000, 32'h4000_0000,
              64'h15, 32'h4080_0000, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_val("mid_rst.int",  bus.int_output, 64'd0);
        check_val("mid_rst.fp",   {32'd0, bus.fp_output}, 64'd0);
        check_val("mid_rst.mode", {63'd0, bus.int_mode}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        apply("post_rst", 32'h0001_0000, 32'h0001_0000, 32'h3FC0_0000, 32'h3FC0_0000,
              64'h0000_0001_0000_0000, 32'h4010_0000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
